stream_memory_reader: RTL and testbench
=======================================

// Module: stream_memory_reader
// PURPOSE
//  Read-side counterpart of the stream-to-memory write path. Accepts a read command
//  (start address, word count), fetches words from a synchronous RAM read port and
//  emits them as one AXI-Stream master packet, with tlast on the final word.
//  Sits between the memory array and a downstream AXI-Stream consumer.
//  Output-side FIFO absorbs RAM latency and downstream backpressure.
// PARAMETERS
//  DATA_WIDTH  32  stream/RAM word width in bits; multiple of 8
//  ADDR_WIDTH  10  RAM word-address width
//  LEN_WIDTH   16  command word-count width
//  FIFO_DEPTH  4   output FIFO entries; power of 2, >=4
// PORTS
//  m01_axis_aclk    in   1             sole clock, all logic rising-edge
//  m01_axis_areset  in   1             asynchronous reset, active-high
//  cmd_valid        in   1             read command valid
//  cmd_ready        out  1             command accepted when valid&ready
//  cmd_addr         in   ADDR_WIDTH    first word address
//  cmd_len          in   LEN_WIDTH     number of words to read
//  busy             out  1             command in progress (FSM not IDLE)
//  mem_rd_en        out  1             RAM read strobe
//  mem_rd_addr      out  ADDR_WIDTH    RAM read address
//  mem_rd_data      in   DATA_WIDTH    RAM data, valid 1 cycle after mem_rd_en
//  m01_axis_tdata   out  DATA_WIDTH    stream data
//  m01_axis_tstrb   out  DATA_WIDTH/8  byte strobes, all ones on every beat
//  m01_axis_tvalid  out  1             beat valid
//  m01_axis_tlast   out  1             final beat of packet
//  m01_axis_tready  in   1             downstream ready
// BEHAVIOUR
//  Reset (async, active-high): cmd_ready=0, busy=0, mem_rd_en=0, mem_rd_addr=0,
//   tvalid=0, tlast=0, tdata=0, tstrb=0; FIFO emptied; in-flight read data dropped.
//  FSM: IDLE -> READ -> DRAIN -> IDLE.
//   IDLE: cmd_ready=1. On cmd handshake latch addr/len. len=0 -> stay IDLE, no beats.
//    len>0 -> READ.
//   READ: issue mem_rd_en when FIFO occupancy + reads in flight - pop this cycle
//    < FIFO_DEPTH. Address increments per issued read and wraps mod 2**ADDR_WIDTH.
//    After the len-th read is issued -> DRAIN.
//   DRAIN: wait until the beat carrying tlast has handshaked -> IDLE (cmd_ready
//    rises the following cycle).
//  Latency: cmd handshake at edge k -> mem_rd_en high k..k+1 -> first tvalid at k+2.
//  Throughput: 1 beat/cycle while tready=1; no bubbles after the first beat.
//  AXIS rules: once tvalid=1, tdata/tlast stay stable until tready; tvalid is never
//   withdrawn without a handshake. tvalid does not depend combinationally on tready.
//  tlast is carried in the FIFO alongside data and set only on word len-1.
//  A new command is never accepted while busy; cmd_valid held across busy is accepted
//   in the first IDLE cycle.
//  tready low for any duration: reads stall by the credit rule, FIFO never overflows.
//  Counters sized LEN_WIDTH; len = 2**LEN_WIDTH-1 supported.
// CONFIGURATION
//  STREAM_MEMORY_READER_STATS_EN defined: adds outputs pkt_count[31:0] (packets with
//   tlast handshaked) and beat_count[31:0] (all beat handshakes); both reset to 0,
//   wrap at 2**32. Not defined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  Shared package stream_memory_pkg: reader state enum (IDLE/READ/DRAIN),
//   AXIS strobe-width helper constant; reused by the write-side controller.
//  Sub-module stream_sync_fifo (DATA_WIDTH+1 wide, FIFO_DEPTH deep, registered
//   output, count output) holds {tlast,tdata}.
// TESTING
//  addr=0x010,len=4, RAM[i]=i*0x11, tready=1 -> beats 0x110,0x121,0x132,0x143 on 4
//   consecutive cycles from k+2, tlast only on 4th, cmd_ready back after.
//  len=0 -> no mem_rd_en, no tvalid, cmd_ready stays 1, busy stays 0.
//  addr=0x3FE,len=4 -> reads 0x3FE,0x3FF,0x000,0x001 in order.
//  len=16, tready toggled 1-of-3 cycles -> all 16 words in order, no loss/duplication,
//   tdata stable while stalled, never more than FIFO_DEPTH words buffered.
//  Reset asserted mid-packet (after 3 of 8 beats) -> all outputs to reset values
//   immediately; next command len=2 yields exactly 2 fresh beats.
//  STATS_EN: 3 packets len=5 -> pkt_count=3, beat_count=15.

Source files
------------

// File: rtl/stream_memory_pkg.sv
// rtl/stream_memory_pkg.sv - shared reader state type and AXIS strobe helper for the stream/memory paths
package stream_memory_pkg;

   // Reader command sequencing: accept, issue reads, wait for the final beat
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } reader_state_t;

   // One strobe bit covers one byte of stream data
   localparam int unsigned AXIS_BITS_PER_STRB = 8;

   // Number of tstrb bits for a given tdata width
   function automatic int unsigned axis_strb_width(input int unsigned data_width);
      return data_width / AXIS_BITS_PER_STRB;
   endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// rtl/stream_sync_fifo.sv - single-clock FIFO with registered storage, head output and occupancy count
module stream_sync_fifo #(
   parameter  int WIDTH = 33,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic [CW-1:0]    count
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pops only take effect on a valid head; a push into a full FIFO is
   // accepted only when the same cycle frees an entry
   always_comb begin
      do_pop  = pop && head_valid;
      do_push = push && ((count != DEPTH_C) || do_pop);
   end

   // Data storage carries no reset; the head is qualified by head_valid
   always_ff @(posedge clk) begin
      if (do_push) begin
         storage[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_data  = storage[rd_ptr];
   assign head_valid = (count != '0);

endmodule

// File: rtl/stream_memory_reader.sv
// rtl/stream_memory_reader.sv - RAM-to-AXIS packet reader; STREAM_MEMORY_READER_STATS_EN adds pkt/beat counters
module stream_memory_reader
   import stream_memory_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    m01_axis_aclk,
   input  logic                    m01_axis_areset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [LEN_WIDTH-1:0]    cmd_len,
   output logic                    busy,
   output logic                    mem_rd_en,
   output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]   mem_rd_data,
   output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
   output logic                    m01_axis_tvalid,
   output logic                    m01_axis_tlast,
`ifdef STREAM_MEMORY_READER_STATS_EN
   output logic [31:0]             pkt_count,
   output logic [31:0]             beat_count,
`endif
   input  logic                    m01_axis_tready
);

   localparam int            STRB_W  = int'(axis_strb_width(DATA_WIDTH));
   localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0]   DEPTH_L = (CW + 1)'(FIFO_DEPTH);
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   reader_state_t          state;
   reader_state_t          next_state;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [LEN_WIDTH-1:0]   remaining_q;
   logic                   cmd_ready_q;
   logic                   rd_pending_q;
   logic                   rd_last_q;

   logic                   cmd_hs;
   logic                   rd_issue;
   logic                   pop;
   logic [CW:0]            occ_after;
   logic                   credit_ok;

   logic [DATA_WIDTH:0]    fifo_head;
   logic                   fifo_valid;
   logic [CW-1:0]          fifo_count;
   logic                   fifo_last;

   assign fifo_last = fifo_head[DATA_WIDTH];
   assign pop       = fifo_valid && m01_axis_tready;
   assign cmd_hs    = cmd_ready_q && cmd_valid;

   // Credit: a new read may issue only if everything already buffered or in
   // flight, less what leaves this cycle, still leaves a free FIFO entry
   always_comb begin
      occ_after = {1'b0, fifo_count}
                + {{CW{1'b0}}, rd_pending_q}
                - {{CW{1'b0}}, pop};
      credit_ok = (occ_after < DEPTH_L);
   end

   // Next-state and read-issue decode
   always_comb begin
      next_state = state;
      rd_issue   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cmd_hs && (cmd_len != '0)) begin
               next_state = ST_READ;
            end
         end
         ST_READ: begin
            if (credit_ok) begin
               rd_issue = 1'b1;
               if (remaining_q == LEN_ONE) begin
                  next_state = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && fifo_last) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // State register; cmd_ready is registered so it stays low through reset
   always_ff @(posedge m01_axis_aclk or posedge m01_axis_areset) begin
      if (m01_axis_areset) begin
         state       <= ST_IDLE;
         cmd_ready_q <= 1'b0;
      end else begin
         state       <= next_state;
         cmd_ready_q <= (next_state == ST_IDLE);
      end
   end

   // Command latch, address/length stepping, and one-cycle read-latency tracking
   always_ff @(posedge m01_axis_aclk or posedge m01_axis_areset) begin
      if (m01_axis_areset) begin
         addr_q       <= '0;
         remaining_q  <= '0;
         rd_pending_q <= 1'b0;
         rd_last_q    <= 1'b0;
      end else begin
         if (cmd_hs) begin
            addr_q      <= cmd_addr;
            remaining_q <= cmd_len;
         end else if (rd_issue) begin
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            remaining_q <= remaining_q - LEN_ONE;
         end
         rd_pending_q <= rd_issue;
         rd_last_q    <= rd_issue && (remaining_q == LEN_ONE);
      end
   end

   stream_sync_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (m01_axis_aclk),
      .rst        (m01_axis_areset),
      .push       (rd_pending_q),
      .push_data  ({rd_last_q, mem_rd_data}),
      .pop        (pop),
      .head_data  (fifo_head),
      .head_valid (fifo_valid),
      .count      (fifo_count)
   );

   assign cmd_ready       = cmd_ready_q;
   assign busy            = (state != ST_IDLE);
   assign mem_rd_en       = rd_issue;
   assign mem_rd_addr     = addr_q;
   assign m01_axis_tvalid = fifo_valid;
   assign m01_axis_tdata  = fifo_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
   assign m01_axis_tlast  = fifo_valid && fifo_last;
   assign m01_axis_tstrb  = {STRB_W{fifo_valid}};

`ifdef STREAM_MEMORY_READER_STATS_EN
   // Handshake counters, free-running modulo 2**32
   always_ff @(posedge m01_axis_aclk or posedge m01_axis_areset) begin
      if (m01_axis_areset) begin
         pkt_count  <= '0;
         beat_count <= '0;
      end else begin
         if (pop) begin
            beat_count <= beat_count + 32'd1;
         end
         if (pop && fifo_last) begin
            pkt_count <= pkt_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_stream_memory_reader.sv
// tb/tb_stream_memory_reader.sv - directed self-checking bench for stream_memory_reader
module tb_stream_memory_reader;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int LW = 16;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          busy;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data = '0;
   logic [DW-1:0] tdata;
   logic [DW/8-1:0] tstrb;
   logic          tvalid;
   logic          tlast;
   logic          tready = 1'b0;
`ifdef STREAM_MEMORY_READER_STATS_EN
   logic [31:0]   pkt_count;
   logic [31:0]   beat_count;
`endif

   int n_pass  = 0;
   int n_total = 0;

   stream_memory_reader #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .LEN_WIDTH  (LW),
      .FIFO_DEPTH (FD)
   ) dut (
      .m01_axis_aclk   (clk),
      .m01_axis_areset (rst),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_addr        (cmd_addr),
      .cmd_len         (cmd_len),
      .busy            (busy),
      .mem_rd_en       (mem_rd_en),
      .mem_rd_addr     (mem_rd_addr),
      .mem_rd_data     (mem_rd_data),
      .m01_axis_tdata  (tdata),
      .m01_axis_tstrb  (tstrb),
      .m01_axis_tvalid (tvalid),
      .m01_axis_tlast  (tlast),
`ifdef STREAM_MEMORY_READER_STATS_EN
      .pkt_count       (pkt_count),
      .beat_count      (beat_count),
`endif
      .m01_axis_tready (tready)
   );

   always #5 clk = ~clk;

   // RAM model: RAM[i] = i*0x11, one-cycle synchronous read
   logic [DW-1:0] ram [1 << AW];
   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i * 32'h11);
   end
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observation records, sampled mid-cycle; each record belongs to the next rising edge
   logic [DW-1:0] beat_data [$];
   bit            beat_last [$];
   int            beat_cyc  [$];
   logic [AW-1:0] rd_addr_q [$];
   int            cmd_cyc   [$];
   int            rd_total, beat_total, outstanding, max_out;
   int            stall_err, strb_bad;
   bit            busy_seen;
   bit            stall_prev;
   logic [DW-1:0] stall_data;
   logic          stall_last;

   always @(negedge clk) begin
      if (!rst) begin
         outstanding = rd_total - beat_total;
         if (outstanding > max_out) max_out = outstanding;
         if (stall_prev && (!tvalid || tdata !== stall_data || tlast !== stall_last)) stall_err++;
         stall_prev = tvalid && !tready;
         stall_data = tdata;
         stall_last = tlast;
         if (tvalid && tstrb !== 4'hF) strb_bad++;
         if (tvalid && tready) begin
            beat_data.push_back(tdata);
            beat_last.push_back(tlast);
            beat_cyc.push_back(cyc + 1);
            beat_total++;
         end
         if (mem_rd_en) begin
            rd_addr_q.push_back(mem_rd_addr);
            rd_total++;
         end
         if (cmd_valid && cmd_ready) cmd_cyc.push_back(cyc + 1);
         if (busy) busy_seen = 1'b1;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clear_obs();
      beat_data.delete(); beat_last.delete(); beat_cyc.delete();
      rd_addr_q.delete(); cmd_cyc.delete();
      rd_total = 0; beat_total = 0; max_out = 0;
      stall_err = 0; strb_bad = 0; busy_seen = 1'b0;
   endtask

   task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, output int k);
      int n;
      n = cmd_cyc.size();
      cmd_addr  = a;
      cmd_len   = l;
      cmd_valid = 1'b1;
      for (int t = 0; t < 200 && cmd_cyc.size() == n; t++) tick(1);
      cmd_valid = 1'b0;
      if (cmd_cyc.size() > n) begin
         k = cmd_cyc[n];
      end else begin
         k = -1;
         n_total++;
         $display("FAIL cmd_accept: got no handshake, required handshake for addr %h", a);
      end
   endtask

   task automatic wait_beats(input int n, input int budget);
      int t;
      t = 0;
      while (beat_data.size() < n && t < budget) begin
         tick(1);
         t++;
      end
      if (beat_data.size() < n) begin
         n_total++;
         $display("FAIL beat_timeout: got %0d beats, required %0d", beat_data.size(), n);
      end
   endtask

   task automatic test_reset();
      tick(2);
      n_total++;
      if ({cmd_ready, busy, mem_rd_en, tvalid, tlast} !== 5'b0)
         $display("FAIL reset_ctrl: got %b, required 00000", {cmd_ready, busy, mem_rd_en, tvalid, tlast});
      else n_pass++;
      n_total++;
      if ({mem_rd_addr, tdata, tstrb} !== '0)
         $display("FAIL reset_data: got addr %h tdata %h tstrb %h, required all zero", mem_rd_addr, tdata, tstrb);
      else n_pass++;
      rst = 1'b0;
      tick(1);
      n_total++;
      if ({cmd_ready, busy} !== 2'b10)
         $display("FAIL post_reset_ready: got ready/busy %b, required 10", {cmd_ready, busy});
      else n_pass++;
   endtask

   task automatic test_basic();
      int k;
      logic [DW-1:0] g;
      clear_obs();
      tready = 1'b1;
      send_cmd(10'h010, 16'd4, k);
      wait_beats(4, 50);
      tick(3);
      n_total++;
      if (beat_data.size() !== 4) $display("FAIL basic_count: got %0d beats, required 4", beat_data.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         g = (i < beat_data.size()) ? beat_data[i] : 'x;
         n_total++;
         if (g !== DW'(32'h110 + i * 32'h11)) $display("FAIL basic_data%0d: got %h, required %h", i, g, 32'h110 + i * 32'h11);
         else n_pass++;
         n_total++;
         if (i >= beat_last.size() || beat_last[i] !== (i == 3)) $display("FAIL basic_last%0d: got wrong tlast, required %0d", i, (i == 3));
         else n_pass++;
         n_total++;
         if (i >= beat_cyc.size() || beat_cyc[i] !== k + 3 + i)
            $display("FAIL basic_timing%0d: got edge %0d, required %0d", i, (i < beat_cyc.size()) ? beat_cyc[i] : -1, k + 3 + i);
         else n_pass++;
      end
      n_total++;
      if (strb_bad !== 0) $display("FAIL basic_tstrb: got %0d bad beats, required 0", strb_bad);
      else n_pass++;
      n_total++;
      if ({cmd_ready, busy} !== 2'b10) $display("FAIL basic_done: got ready/busy %b, required 10", {cmd_ready, busy});
      else n_pass++;
   endtask

   task automatic test_len_zero();
      int k;
      clear_obs();
      send_cmd(10'h055, 16'd0, k);
      tick(6);
      n_total++;
      if (rd_addr_q.size() !== 0 || beat_data.size() !== 0)
         $display("FAIL len0_activity: got %0d reads %0d beats, required 0 0", rd_addr_q.size(), beat_data.size());
      else n_pass++;
      n_total++;
      if ({cmd_ready, busy_seen} !== 2'b10)
         $display("FAIL len0_state: got ready/busy_seen %b, required 10", {cmd_ready, busy_seen});
      else n_pass++;
   endtask

   task automatic test_wrap();
      int k;
      logic [AW-1:0] ea [4];
      logic [DW-1:0] ed [4];
      logic [AW-1:0] ga;
      logic [DW-1:0] gd;
      ea[0] = 10'h3FE; ea[1] = 10'h3FF; ea[2] = 10'h000; ea[3] = 10'h001;
      ed[0] = 32'h43DE; ed[1] = 32'h43EF; ed[2] = 32'h0; ed[3] = 32'h11;
      clear_obs();
      send_cmd(10'h3FE, 16'd4, k);
      wait_beats(4, 50);
      tick(2);
      for (int i = 0; i < 4; i++) begin
         ga = (i < rd_addr_q.size()) ? rd_addr_q[i] : 'x;
         gd = (i < beat_data.size()) ? beat_data[i] : 'x;
         n_total++;
         if (ga !== ea[i]) $display("FAIL wrap_addr%0d: got %h, required %h", i, ga, ea[i]);
         else n_pass++;
         n_total++;
         if (gd !== ed[i]) $display("FAIL wrap_data%0d: got %h, required %h", i, gd, ed[i]);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int k;
      int bad;
      clear_obs();
      tready = 1'b0;
      send_cmd(10'h040, 16'd16, k);
      for (int t = 0; t < 400 && beat_data.size() < 16; t++) begin
         tready = (t % 3 == 0);
         tick(1);
      end
      tready = 1'b1;
      tick(4);
      n_total++;
      if (beat_data.size() !== 16 || rd_addr_q.size() !== 16)
         $display("FAIL bp_count: got %0d beats %0d reads, required 16 16", beat_data.size(), rd_addr_q.size());
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (i >= beat_data.size() || beat_data[i] !== DW'(32'h440 + i * 32'h11) || beat_last[i] !== (i == 15)) bad++;
      end
      n_total++;
      if (bad !== 0) $display("FAIL bp_order: got %0d wrong beats, required 0", bad);
      else n_pass++;
      n_total++;
      if (stall_err !== 0) $display("FAIL bp_stable: got %0d unstable stalls, required 0", stall_err);
      else n_pass++;
      n_total++;
      if (max_out !== FD) $display("FAIL bp_occupancy: got max %0d buffered, required %0d", max_out, FD);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int k;
      clear_obs();
      tready = 1'b1;
      send_cmd(10'h080, 16'd8, k);
      wait_beats(3, 50);
      rst = 1'b1;
      #1;
      n_total++;
      if ({cmd_ready, busy, mem_rd_en, tvalid, tlast} !== 5'b0)
         $display("FAIL midrst_ctrl: got %b, required 00000", {cmd_ready, busy, mem_rd_en, tvalid, tlast});
      else n_pass++;
      n_total++;
      if ({mem_rd_addr, tdata, tstrb} !== '0)
         $display("FAIL midrst_data: got addr %h tdata %h tstrb %h, required all zero", mem_rd_addr, tdata, tstrb);
      else n_pass++;
      n_total++;
      if (beat_data.size() !== 3 || beat_data[2] !== 32'h8A2)
         $display("FAIL midrst_prefix: got %0d beats, required 3 ending 8a2", beat_data.size());
      else n_pass++;
      tick(2);
      rst = 1'b0;
      tick(1);
      clear_obs();
      send_cmd(10'h020, 16'd2, k);
      wait_beats(2, 50);
      tick(6);
      n_total++;
      if (beat_data.size() !== 2 || beat_data[0] !== 32'h220 || beat_data[1] !== 32'h231 ||
          beat_last[0] !== 1'b0 || beat_last[1] !== 1'b1)
         $display("FAIL midrst_fresh: got %0d beats first %h, required 2 beats 220 231", beat_data.size(),
                  (beat_data.size() > 0) ? beat_data[0] : 32'hx);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] ed [5];
      bit            el [5];
      int            bad;
      ed[0] = 32'h1100; ed[1] = 32'h1111; ed[2] = 32'h1122; ed[3] = 32'h2200; ed[4] = 32'h2211;
      el[0] = 0; el[1] = 0; el[2] = 1; el[3] = 0; el[4] = 1;
      clear_obs();
      tready = 1'b1;
      cmd_addr = 10'h100; cmd_len = 16'd3; cmd_valid = 1'b1;
      for (int t = 0; t < 50 && cmd_cyc.size() < 1; t++) tick(1);
      cmd_addr = 10'h200; cmd_len = 16'd2;
      for (int t = 0; t < 50 && cmd_cyc.size() < 2; t++) tick(1);
      cmd_valid = 1'b0;
      wait_beats(5, 50);
      tick(3);
      n_total++;
      if (cmd_cyc.size() !== 2 || beat_cyc.size() < 3 || cmd_cyc[1] !== beat_cyc[2] + 1)
         $display("FAIL b2b_accept: got %0d cmds second at %0d, required second at tlast edge+1 (%0d)", cmd_cyc.size(),
                  (cmd_cyc.size() > 1) ? cmd_cyc[1] : -1, (beat_cyc.size() > 2) ? beat_cyc[2] + 1 : -1);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (i >= beat_data.size() || beat_data[i] !== ed[i] || beat_last[i] !== el[i]) bad++;
      end
      n_total++;
      if (bad !== 0 || beat_data.size() !== 5) $display("FAIL b2b_beats: got %0d wrong of %0d, required 0 of 5", bad, beat_data.size());
      else n_pass++;
   endtask

`ifdef STREAM_MEMORY_READER_STATS_EN
   task automatic test_stats();
      int k;
      n_total++;
      if ({pkt_count, beat_count} !== 64'd0) $display("FAIL stats_reset: got %0d/%0d, required 0/0", pkt_count, beat_count);
      else n_pass++;
      clear_obs();
      tready = 1'b1;
      for (int p = 0; p < 3; p++) begin
         send_cmd(10'h300, 16'd5, k);
         wait_beats(5 * (p + 1), 60);
         tick(2);
      end
      n_total++;
      if (pkt_count !== 32'd3 || beat_count !== 32'd15)
         $display("FAIL stats_counts: got %0d pkts %0d beats, required 3 15", pkt_count, beat_count);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
`ifdef STREAM_MEMORY_READER_STATS_EN
      test_stats();
`endif
      test_basic();
      test_len_zero();
      test_wrap();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
